dffn_ureg: RTL and testbench

- Parametrised successor to the single-bit GAL D flip-flop macrocell. Adds N-bit width, clock enable, synchronous reset, output enable and four operating modes: hold, parallel load, bidirectional shift, and up-count.
- Sits behind the GAL pin model as a registered I/O bank. The bench drives the inputs and samples Q through the testvec checker with io_dly = 21 ns.

---
 rtl/dffn_ureg_pkg.sv | 15 +
 rtl/dffn_ureg_next.sv | 45 ++++
 rtl/dffn_ureg.sv | 50 +++++
 tb/tb_dffn_ureg.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dffn_ureg_pkg.sv
// Shared definitions for the dffn_ureg registered I/O bank:
// operating-mode encodings and shift-direction constants.
package dffn_ureg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/dffn_ureg_next.sv
// Combinational next-state function for the dffn_ureg register:
// hold, load, bidirectional shift and wrapping/saturating count.
module dffn_ureg_next
  import dffn_ureg_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             si,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             tc
);

  logic all_ones;

  // The loops leave only the SI assignment when WIDTH is 1,
  // so a 1-bit register simply takes SI in either direction.
  always_comb begin
    all_ones = &r;
    r_next   = r;
    tc       = (mode == MODE_COUNT) && all_ones;
    case (mode_e'(mode))
      MODE_HOLD: r_next = r;
      MODE_LOAD: r_next = d;
      MODE_SHIFT: begin
        if (dir == DIR_UP) begin
          for (int i = 1; i < WIDTH; i++) r_next[i] = r[i-1];
          r_next[0] = si;
        end else begin
          for (int i = 0; i < WIDTH - 1; i++) r_next[i] = r[i+1];
          r_next[WIDTH-1] = si;
        end
      end
      MODE_COUNT: begin
        if (!((SATURATE != 0) && all_ones)) r_next = r + WIDTH'(1);
      end
      default: r_next = r;
    endcase
  end

endmodule

// File: rtl/dffn_ureg.sv
// Registered I/O bank shell: holds R, applies RESET/CE priority,
// and drives the tristated Q plus combinational SO and TC.
module dffn_ureg
  import dffn_ureg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SATURATE  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             OE,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             TC
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic             tc_mode;

  dffn_ureg_next #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_next (
    .r     (r),
    .mode  (MODE),
    .dir   (DIR),
    .si    (SI),
    .d     (D),
    .r_next(r_next),
    .tc    (tc_mode)
  );

  // RESET wins over CE; CE gates every other update.
  always_ff @(posedge CLK) begin
    if (RESET)   r <= RESET_VAL;
    else if (CE) r <= r_next;
  end

  assign Q  = OE ? r : {WIDTH{1'bz}};
  assign SO = (DIR == DIR_DN) ? r[0] : r[WIDTH-1];
  assign TC = CE & tc_mode;

endmodule

// File: tb/tb_dffn_ureg.sv
// Self-checking bench for dffn_ureg: directed test-plan steps followed by
// random stimulus, against a wrapping (dut0) and a saturating (dut1) instance.
module tb_dffn_ureg;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         reset_i, ce_i, oe_i, dir_i, si_i;
  logic [1:0]   mode_i;
  logic [W-1:0] d_i;

  // Pull-ups make a released Q bus read as all ones.
  tri1  [W-1:0] q0, q1;
  logic         so0, so1, tc0, tc1;

  int vectors = 0;
  int miscompares = 0;
  int m0, m1;

  always #5 CLK = ~CLK;

  dffn_ureg #(.WIDTH(W), .RESET_VAL(4'h0), .SATURATE(0)) dut0 (
    .CLK(CLK), .RESET(reset_i), .CE(ce_i), .OE(oe_i), .MODE(mode_i),
    .DIR(dir_i), .SI(si_i), .D(d_i), .Q(q0), .SO(so0), .TC(tc0)
  );

  dffn_ureg #(.WIDTH(W), .RESET_VAL(4'h0), .SATURATE(1)) dut1 (
    .CLK(CLK), .RESET(reset_i), .CE(ce_i), .OE(oe_i), .MODE(mode_i),
    .DIR(dir_i), .SI(si_i), .D(d_i), .Q(q1), .SO(so1), .TC(tc1)
  );

  // Reference model: the register as an integer in 0..MAX.
  function automatic int modelNext(int r, int sat);
    if (reset_i) return 0;
    if (!ce_i) return r;
    case (mode_i)
      2'b01: return int'(d_i);
      2'b10: return dir_i ? ((r / 2) + (si_i ? (1 << (W - 1)) : 0))
                          : (((r * 2) + (si_i ? 1 : 0)) % (MAX + 1));
      2'b11: return (sat != 0 && r == MAX) ? r : (r + 1) % (MAX + 1);
      default: return r;
    endcase
  endfunction

  task automatic doCheck(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [W-1:0] r0, r1;
    r0 = W'(m0);
    r1 = W'(m1);
    doCheck("q0",  q0, oe_i ? r0 : {W{1'b1}});
    doCheck("so0", {3'b0, so0}, {3'b0, dir_i ? r0[0] : r0[W-1]});
    doCheck("tc0", {3'b0, tc0}, {3'b0, ce_i && mode_i == 2'b11 && m0 == MAX});
    doCheck("q1",  q1, oe_i ? r1 : {W{1'b1}});
    doCheck("so1", {3'b0, so1}, {3'b0, dir_i ? r1[0] : r1[W-1]});
    doCheck("tc1", {3'b0, tc1}, {3'b0, ce_i && mode_i == 2'b11 && m1 == MAX});
  endtask

  task automatic applyStimulus(input logic rst, input logic ce, input logic oe,
                               input logic [1:0] mode, input logic dir,
                               input logic si, input logic [W-1:0] d);
    reset_i = rst; ce_i = ce; oe_i = oe; mode_i = mode;
    dir_i = dir; si_i = si; d_i = d;
    @(posedge CLK);
    m0 = modelNext(m0, 0);
    m1 = modelNext(m1, 1);
    #1;
    checkOutput();
  endtask

  initial begin
    reset_i = 1'b1; ce_i = 1'b0; oe_i = 1'b1; mode_i = 2'b00;
    dir_i = 1'b0; si_i = 1'b0; d_i = '0;
    m0 = 0; m1 = 0;
    #2;

    // Reset and output enable.
    applyStimulus(1, 0, 1, 2'b00, 0, 0, 4'h0);
    doCheck("reset_q", q0, 4'h0);
    oe_i = 1'b0; #1; checkOutput();
    oe_i = 1'b1; #1; checkOutput();
    doCheck("oe_restore_q", q0, 4'h0);

    // Load, then CE gating, then reset with CE low.
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 4'hA);
    doCheck("load_q", q0, 4'hA);
    repeat (3) applyStimulus(0, 0, 1, 2'b01, 0, 0, 4'h5);
    doCheck("ce_hold_q", q0, 4'hA);
    applyStimulus(1, 0, 1, 2'b01, 0, 0, 4'h5);
    doCheck("reset_ce0_q", q0, 4'h0);

    // Shift toward MSB with SI 1,0,1,1 then toward LSB with SI 0.
    applyStimulus(0, 1, 1, 2'b10, 0, 1, 4'h0);
    applyStimulus(0, 1, 1, 2'b10, 0, 0, 4'h0);
    applyStimulus(0, 1, 1, 2'b10, 0, 1, 4'h0);
    applyStimulus(0, 1, 1, 2'b10, 0, 1, 4'h0);
    doCheck("shl_q", q0, 4'hB);
    doCheck("shl_so", {3'b0, so0}, 4'h1);
    repeat (2) applyStimulus(0, 1, 1, 2'b10, 1, 0, 4'h0);
    doCheck("shr_q", q0, 4'h2);
    doCheck("shr_so", {3'b0, so0}, 4'h0);

    // Count through wrap from D; dut1 saturates at F.
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 4'hD);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("cnt_e", q0, 4'hE);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("cnt_f", q0, 4'hF);
    doCheck("cnt_tc", {3'b0, tc0}, 4'h1);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("cnt_wrap", q0, 4'h0);
    doCheck("cnt_sat", q1, 4'hF);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("cnt_1", q0, 4'h1);

    // Saturating count from E, with OE toggled mid-sequence.
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 4'hE);
    applyStimulus(0, 1, 0, 2'b11, 0, 0, 4'h0);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("sat_q", q1, 4'hF);
    doCheck("sat_tc", {3'b0, tc1}, 4'h1);

    // Reset aborts a count; counting resumes from RESET_VAL.
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 4'h3);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("rc_4", q0, 4'h4);
    applyStimulus(1, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("rc_0", q0, 4'h0);
    applyStimulus(0, 1, 1, 2'b11, 0, 0, 4'h0);
    doCheck("rc_1", q0, 4'h1);

    // Input glitches between edges must not affect R.
    mode_i = 2'b01; d_i = 4'h9; #2;
    applyStimulus(0, 1, 1, 2'b00, 0, 0, 4'h0);
    doCheck("glitch_q", q0, 4'h1);

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                    ($urandom_range(4) != 0), 2'($urandom_range(3)),
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    4'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
